// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF-stage control. Decides PC advance/hold/redirect and
// IF/ID load/hold/flush, sequences boot bubbles and halt/resume, buffers one
// redirect that arrives while halted, and keeps fetch-side perf counters.
module fetch_sequencer #(
  parameter int unsigned BOOT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_req,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [63:0] redirect_pc,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        fetch_valid,
  output logic [31:0] fetch_count,
  output logic [15:0] stall_count
);

  localparam int unsigned BOOT_CNT_W = 4;
  localparam int unsigned PC_W       = 64;
  localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = BOOT_CNT_W'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [BOOT_CNT_W-1:0] boot_cnt, boot_cnt_nxt;
  logic                  pend_valid, pend_valid_nxt;
  logic [PC_W-1:0]       pend_pc, pend_pc_nxt;
  logic                  fetch_inc;
  logic                  stall_inc;

  // State, pending redirect and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_BOOT;
      boot_cnt    <= '0;
      pend_valid  <= 1'b0;
      pend_pc     <= '0;
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      state      <= state_nxt;
      boot_cnt   <= boot_cnt_nxt;
      pend_valid <= pend_valid_nxt;
      pend_pc    <= pend_pc_nxt;
      if (fetch_inc) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (stall_inc && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

  // Next-state and combinational fetch-control outputs.
  always_comb begin
    state_nxt      = state;
    boot_cnt_nxt   = boot_cnt;
    pend_valid_nxt = pend_valid;
    pend_pc_nxt    = pend_pc;
    fetch_inc      = 1'b0;
    stall_inc      = 1'b0;
    pc_we          = 1'b0;
    pc_sel         = 1'b0;
    redirect_pc    = '0;
    ifid_we        = 1'b1;
    ifid_flush     = 1'b1;
    fetch_valid    = 1'b0;

    unique case (state)
      ST_BOOT: begin
        boot_cnt_nxt = boot_cnt + BOOT_CNT_W'(1);
        if (boot_cnt == BOOT_LAST) begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (br_taken) begin
          pc_we       = 1'b1;
          pc_sel      = 1'b1;
          redirect_pc = br_target;
        end else if (stall_req) begin
          ifid_we    = 1'b0;
          ifid_flush = 1'b0;
          stall_inc  = 1'b1;
        end else if (halt_req) begin
          state_nxt = ST_HALT;
        end else begin
          pc_we       = 1'b1;
          ifid_flush  = 1'b0;
          fetch_valid = 1'b1;
          fetch_inc   = 1'b1;
        end
      end

      ST_HALT: begin
        if (resume) begin
          state_nxt      = ST_RUN;
          pend_valid_nxt = 1'b0;
          pend_pc_nxt    = '0;
          // A branch arriving with resume is newer than the buffered one.
          if (br_taken) begin
            pc_we       = 1'b1;
            pc_sel      = 1'b1;
            redirect_pc = br_target;
          end else if (pend_valid) begin
            pc_we       = 1'b1;
            pc_sel      = 1'b1;
            redirect_pc = pend_pc;
          end
        end else if (br_taken) begin
          pend_valid_nxt = 1'b1;
          pend_pc_nxt    = br_target;
        end
      end

      default: begin
        state_nxt = ST_BOOT;
      end
    endcase

    // Reset holds fetch in a flushed bubble regardless of current state.
    if (reset) begin
      pc_we       = 1'b0;
      pc_sel      = 1'b0;
      redirect_pc = '0;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b1;
      fetch_valid = 1'b0;
    end
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control sequencer for the instruction-fetch stage. Each cycle it decides whether the PC advances, holds, or is redirected to a branch target, and whether the IF/ID pipeline register loads, holds or is flushed. It also owns boot-time fetch bubbles and the halt/resume protocol, including a one-entry buffer for a branch redirect that arrives while fetch is halted. It sits between the hazard/branch-resolution logic and the IF datapath (PC register, +4 adder, redirect mux, instruction memory) and keeps fetch-side performance counters.

## Interface
Parameters:
- BOOT_CYCLES, 1, number of bubble cycles after reset before the first fetch. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall_req  in  1  load-use hazard from ID; hold IF and IF/ID
- br_taken  in  1  branch resolved taken this cycle
- br_target  in  64  branch target PC, valid when br_taken=1
- halt_req  in  1  level; decoded halt in ID
- resume  in  1  single-cycle pulse; restart fetch from HALT
- pc_we  out  1  PC register write enable
- pc_sel  out  1  1 = PC next value is redirect_pc; 0 = PC+4
- redirect_pc  out  64  redirect target; 0 when pc_sel=0
- ifid_we  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID loads a bubble (valid=0)
- fetch_valid  out  1  instruction presented to IF/ID this cycle is real
- fetch_count  out  32  count of valid fetches; wraps
- stall_count  out  16  count of stall cycles; saturates at 0xFFFF

## Operation
- States: BOOT, RUN, HALT. Registers: state, boot_cnt (4 bit), pend_valid, pend_pc (64), fetch_count, stall_count.
- Outputs are combinational from state and inputs; counters and pend are registered.
- BOOT: pc_we=0, pc_sel=0, ifid_we=1, ifid_flush=1, fetch_valid=0. All inputs ignored. boot_cnt increments. After BOOT_CYCLES cycles, go to RUN.
- RUN, priority br_taken > stall_req > halt_req:
  - br_taken: pc_we=1, pc_sel=1, redirect_pc=br_target, ifid_we=1, ifid_flush=1, fetch_valid=0. Stay in RUN.
  - stall_req: pc_we=0, ifid_we=0, ifid_flush=0, fetch_valid=0. stall_count+1, saturating.
  - halt_req: pc_we=0, ifid_we=1, ifid_flush=1, fetch_valid=0. Go to HALT.
  - none of the above: pc_we=1, pc_sel=0, ifid_we=1, ifid_flush=0, fetch_valid=1. fetch_count+1, wrapping.
- HALT: pc_we=0, ifid_we=1, ifid_flush=1, fetch_valid=0. stall_req and halt_req are ignored.
  - br_taken without resume: pend_valid<=1, pend_pc<=br_target. The latest branch overwrites any pending one.
  - resume with br_taken: redirect to br_target (pc_we=1, pc_sel=1). Clear pend. Go to RUN.
  - resume with pend_valid and no br_taken: redirect to pend_pc. Clear pend. Go to RUN.
  - resume with neither: outputs as HALT. Go to RUN; fetch restarts next cycle.
- Rule: ifid_flush=1 implies ifid_we=1. pc_sel=1 implies pc_we=1.

## Timing
- Reset: state=BOOT, boot_cnt=0, pend_valid=0, pend_pc=0, fetch_count=0, stall_count=0.
  - While reset=1: pc_we=0, pc_sel=0, redirect_pc=0, ifid_we=1, ifid_flush=1, fetch_valid=0.
- BOOT occupies exactly BOOT_CYCLES cycles with reset=0. The first possible fetch_valid=1 is at cycle BOOT_CYCLES+1 after reset deasserts.
- Reset asserted mid-operation (any state, pending redirect or not) returns to BOOT next edge and discards pend.
- Redirect has zero-cycle decision latency: the PC holds br_target after the edge on which br_taken=1 was sampled.
- A stall holds the PC and IF/ID for exactly the cycles stall_req=1. No extra recovery cycle.
- HALT entry is immediate. Exit completes on the edge after the resume pulse.
- resume outside HALT is ignored. br_taken in BOOT is ignored.

## Test plan
- Boot: BOOT_CYCLES=3, release reset, idle inputs -> fetch_valid=0 for 3 cycles, then 1 every cycle; fetch_count=5 after 8 cycles.
- Stall: RUN, stall_req=1 for 4 cycles -> pc_we=0 and ifid_we=0 for 4 cycles; stall_count=4; fetch_count frozen; normal fetch on the next cycle.
- Branch over stall: br_taken=1, br_target=0x40, stall_req=1 in the same cycle -> pc_we=1, pc_sel=1, redirect_pc=0x40, ifid_flush=1; stall_count unchanged.
- Halt with buffered branch: halt_req -> HALT; br_taken with 0x100 then 0x200 in later cycles; resume -> redirect_pc=0x200, pc_we=1; next cycle RUN with fetch_valid=1.
- Simultaneous resume and branch: HALT with pend_pc=0x80, resume and br_taken with br_target=0xC0 together -> redirect_pc=0xC0; pend_valid=0.
- Saturation and reset: force 70000 stall cycles -> stall_count=0xFFFF; assert reset while in HALT with a pending redirect -> all counters 0, pend cleared, BOOT re-entered.
